// File: rtl/mda_attrib.sv
// MDA attribute/pixel stage: serialises a 9-column character cell from a
// font ROM row, applies the MDA attribute rules (blank, inverse, underline,
// blink, intensity), the cursor override and display gating, and drives a
// registered video/intensity pair. All pixel-rate state advances on pix_en.
module mda_attrib (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       load,
  input  logic [7:0] font_byte,
  input  logic [7:0] char_code,
  input  logic [7:0] attr,
  input  logic       cursor,
  input  logic       underline_row,
  input  logic       display_enable,
  input  logic       blink_en,
  input  logic       vsync,
  output logic       video,
  output logic       intensity
);

  localparam logic [3:0] LAST_COL = 4'd9;

  // Latched cell data; char_code is only ever needed as "is line graphics".
  logic [7:0] r_font;
  logic       r_gfx;
  logic [7:0] r_attr;
  logic       r_cursor;
  logic       r_ul;
  logic [3:0] r_col;

  // Stage 1: pixel of the column held in r_col plus that cell's attributes.
  logic       r_s1_pix;
  logic [7:0] r_s1_attr;
  logic       r_s1_cursor;
  logic       r_s1_ul;
  logic       r_s1_de;

  // Blink timebase.
  logic       r_vsync_d;
  logic [4:0] r_blink;

  // Cell values as they will be after this pix_en (fresh inputs on load).
  logic [7:0] w_font_n;
  logic       w_gfx_n;
  logic [7:0] w_attr_n;
  logic       w_cursor_n;
  logic       w_ul_n;
  logic [3:0] w_col_n;
  logic       w_pix;

  // Stage-2 decode.
  logic       w_blank;
  logic       w_inverse;
  logic       w_ul_class;
  logic       w_fg;
  logic       w_video;
  logic       w_intensity;

  // Select the cell/column being entered: a load starts column 0 of the new
  // cell straight from the inputs, so pixel 0 reaches stage 1 on the load edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_font_n   = r_font;
    w_gfx_n    = r_gfx;
    w_attr_n   = r_attr;
    w_cursor_n = r_cursor;
    w_ul_n     = r_ul;
    w_col_n    = (r_col >= LAST_COL) ? LAST_COL : r_col + 4'd1;
    if (load) begin
      w_font_n   = font_byte;
      w_gfx_n    = (char_code >= 8'hC0) && (char_code <= 8'hDF);
      w_attr_n   = attr;
      w_cursor_n = cursor;
      w_ul_n     = underline_row;
      w_col_n    = 4'd0;
    end
  end

  // Cell pixel: font bits MSB-first, column 8 repeats bit0 for line graphics, column 9 is dark.
  always_comb begin
    w_pix = 1'b0;
    if (w_col_n < 4'd8) begin
      w_pix = w_font_n[3'd7 - w_col_n[2:0]];
    end else if (w_col_n == 4'd8) begin
      w_pix = w_gfx_n & w_font_n[0];
    end
  end

  // Attribute classes, blink, cursor override and display gating from stage 1.
  always_comb begin
    w_blank    = ((r_s1_attr & 8'h77) == 8'h00);
    w_inverse  = ((r_s1_attr & 8'h77) == 8'h70);
    w_ul_class = (r_s1_attr[2:0] == 3'b001);
    w_fg       = r_s1_pix | (w_ul_class & r_s1_ul);
    if (blink_en && r_s1_attr[7] && !r_blink[4]) begin
      w_fg = 1'b0;
    end
    if (w_blank) begin
      w_video = 1'b0;
    end else if (w_inverse) begin
      w_video = ~w_fg;
    end else begin
      w_video = w_fg;
    end
    if (r_s1_cursor && r_blink[3]) begin
      w_video = 1'b1;
    end
    w_intensity = r_s1_attr[3] & ~w_blank;
    if (!r_s1_de) begin
      w_video     = 1'b0;
      w_intensity = 1'b0;
    end
  end

  // Blink counter: counts vsync rising edges on every clk, independent of pix_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments make every register see pre-edge values, so ordering does not matter.
      r_vsync_d <= 1'b0;
      r_blink   <= 5'd0;
    end else begin
      r_vsync_d <= vsync;
      if (vsync && !r_vsync_d) begin
        r_blink <= r_blink + 5'd1;
      end
    end
  end

  // Pixel pipeline: cell latch, column counter, stage 1 and stage 2 all step on pix_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_font      <= 8'h00;
      r_gfx       <= 1'b0;
      r_attr      <= 8'h00;
      r_cursor    <= 1'b0;
      r_ul        <= 1'b0;
      r_col       <= LAST_COL;
      r_s1_pix    <= 1'b0;
      r_s1_attr   <= 8'h00;
      r_s1_cursor <= 1'b0;
      r_s1_ul     <= 1'b0;
      r_s1_de     <= 1'b0;
      video       <= 1'b0;
      intensity   <= 1'b0;
    end else if (pix_en) begin
      r_font      <= w_font_n;
      r_gfx       <= w_gfx_n;
      r_attr      <= w_attr_n;
      r_cursor    <= w_cursor_n;
      r_ul        <= w_ul_n;
      r_col       <= w_col_n;
      r_s1_pix    <= w_pix;
      r_s1_attr   <= w_attr_n;
      r_s1_cursor <= w_cursor_n;
      r_s1_ul     <= w_ul_n;
      r_s1_de     <= display_enable;
      video       <= w_video;
      intensity   <= w_intensity;
    end
  end

endmodule
